// File: rtl/serv_ifetch_pkg.sv
// serv_ifetch_pkg: shared types and constants for the instruction-fetch stage.
//   state_e     - fetch FSM states (IDLE, WAIT)
//   ALIGN_OK    - value of pc[1:0] for a word-aligned fetch address
//   wdog_width  - bit width of the watchdog counter for a given TIMEOUT
package serv_ifetch_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [1:0] ALIGN_OK = 2'b00;

  // clog2(TIMEOUT+1), never below one bit so the counter always exists.
  function automatic int wdog_width(input int timeout);
    if (timeout < 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(timeout + 32'sd1);
    end
  endfunction

endpackage

// File: rtl/serv_ifetch_if.sv
// serv_ifetch_if: Wishbone classic read-only instruction bus.
//   adr - word address (driven by the fetch stage)
//   cyc - cycle/strobe (driven by the fetch stage)
//   rdt - read data    (driven by memory)
//   ack - acknowledge  (driven by memory)
interface serv_ifetch_if;
  logic [31:0] adr;
  logic        cyc;
  logic [31:0] rdt;
  logic        ack;

  modport master (output adr, output cyc, input rdt, input ack);
  modport slave  (input adr, input cyc, output rdt, output ack);
endinterface

// File: rtl/serv_ifetch_wdog.sv
// serv_ifetch_wdog: bus watchdog for the fetch stage.
//   i_clk, i_rst - clock, asynchronous active-high reset
//   i_clr        - synchronous clear (held while no fetch is outstanding)
//   i_en         - count one WAIT cycle
//   o_expire     - combinational: this enabled cycle is the TIMEOUT-th one
// The count saturates at TIMEOUT and never wraps. TIMEOUT = 0 disables expiry.
module serv_ifetch_wdog
  import serv_ifetch_pkg::*;
#(
  parameter int TIMEOUT = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int W = wdog_width(TIMEOUT);
  localparam logic [W-1:0] SAT   = W'(TIMEOUT);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_r;

  // Watchdog count: cleared outside WAIT, saturating increment inside it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_r <= '0;
    end else if (i_clr) begin
      cnt_r <= '0;
    end else if (i_en && (cnt_r != SAT)) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_disabled
      assign o_expire = 1'b0;
    end else begin : g_enabled
      assign o_expire = i_en && (cnt_r == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/serv_ifetch.sv
// serv_ifetch: instruction-fetch stage feeding the immediate and control decoders.
// Runs one Wishbone classic read per accepted request and hands the word on
// with a single-cycle strobe.
//   i_clk, i_rst  - clock, asynchronous active-high reset
//   i_fetch_req   - fetch request at i_pc (only looked at in IDLE)
//   i_pc          - fetch address
//   i_flush       - abandon the outstanding fetch / block a same-cycle request
//   ibus          - instruction bus (master side)
//   o_wb_en       - one-cycle strobe: o_wb_rdt holds a new instruction
//   o_wb_rdt      - last fetched instruction, held until the next accepted ack
//   o_misalign    - one-cycle pulse: request with pc[1:0] != 0
//   o_bus_err     - one-cycle pulse: watchdog expired
//   o_busy        - high while a fetch is outstanding
module serv_ifetch
  import serv_ifetch_pkg::*;
#(
  parameter int TIMEOUT = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_fetch_req,
  input  logic [31:0]          i_pc,
  input  logic                 i_flush,
  serv_ifetch_if.master        ibus,
  output logic                 o_wb_en,
  output logic [31:0]          o_wb_rdt,
  output logic                 o_misalign,
  output logic                 o_bus_err,
  output logic                 o_busy
);

  state_e      state_r;
  state_e      state_nxt_s;
  logic [31:0] adr_r;
  logic [31:0] adr_nxt_s;
  logic        cyc_r;
  logic [31:0] wb_rdt_r;
  logic [31:0] wb_rdt_nxt_s;
  logic        wb_en_r;
  logic        wb_en_nxt_s;
  logic        misalign_r;
  logic        misalign_nxt_s;
  logic        bus_err_r;
  logic        bus_err_nxt_s;
  logic        expire_s;
  logic        wdog_clr_s;
  logic        wdog_en_s;

  // Count only while a fetch is outstanding; hold at zero whenever the next
  // state is IDLE so the count is already clear on the first IDLE cycle.
  assign wdog_en_s  = (state_r == WAIT);
  assign wdog_clr_s = (state_nxt_s != WAIT);

  serv_ifetch_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (wdog_clr_s),
    .i_en     (wdog_en_s),
    .o_expire (expire_s)
  );

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and next-output decode; in WAIT flush beats ack beats timeout.
  always_comb begin
    state_nxt_s    = state_r;
    adr_nxt_s      = adr_r;
    wb_rdt_nxt_s   = wb_rdt_r;
    wb_en_nxt_s    = 1'b0;
    misalign_nxt_s = 1'b0;
    bus_err_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_fetch_req && !i_flush) begin
          if (i_pc[1:0] != ALIGN_OK) begin
            misalign_nxt_s = 1'b1;
          end else begin
            adr_nxt_s   = i_pc;
            state_nxt_s = WAIT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (i_flush) begin
          state_nxt_s = IDLE;
        end else if (ibus.ack) begin
          wb_rdt_nxt_s = ibus.rdt;
          wb_en_nxt_s  = 1'b1;
          state_nxt_s  = IDLE;
        end else if (expire_s) begin
          bus_err_nxt_s = 1'b1;
          state_nxt_s   = IDLE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Bus, data and pulse output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      adr_r      <= 32'h0000_0000;
      cyc_r      <= 1'b0;
      wb_rdt_r   <= 32'h0000_0000;
      wb_en_r    <= 1'b0;
      misalign_r <= 1'b0;
      bus_err_r  <= 1'b0;
    end else begin
      adr_r      <= adr_nxt_s;
      cyc_r      <= (state_nxt_s == WAIT);
      wb_rdt_r   <= wb_rdt_nxt_s;
      wb_en_r    <= wb_en_nxt_s;
      misalign_r <= misalign_nxt_s;
      bus_err_r  <= bus_err_nxt_s;
    end
  end

  assign ibus.adr   = adr_r;
  assign ibus.cyc   = cyc_r;
  assign o_wb_en    = wb_en_r;
  assign o_wb_rdt   = wb_rdt_r;
  assign o_misalign = misalign_r;
  assign o_bus_err  = bus_err_r;
  assign o_busy     = (state_r == WAIT);

endmodule

// File: doc/serv_ifetch.md
# serv_ifetch

Instruction-fetch stage directly upstream of the immediate decoder and control decoder. Accepts a fetch request with the current PC, runs one Wishbone classic read on the instruction bus, and delivers the fetched word with a one-cycle `o_wb_en` strobe. The decoders latch the instruction on that strobe, bits [31:7] for the immediate/register-address decoder. Handles misaligned PCs, flushes of an in-flight fetch, and a bus watchdog timeout.

## Interface
- `TIMEOUT`, 0: watchdog limit in WAIT cycles; 0 disables the watchdog.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_fetch_req`  in  1  request a fetch at `i_pc`; sampled only in IDLE.
- `i_pc`  in  32  fetch address.
- `i_flush`  in  1  abandon the outstanding fetch, or block a request in the same cycle.
- `o_ibus_adr`  out  32  Wishbone address, registered.
- `o_ibus_cyc`  out  1  Wishbone cycle/strobe, registered.
- `i_ibus_rdt`  in  32  Wishbone read data.
- `i_ibus_ack`  in  1  Wishbone acknowledge.
- `o_wb_en`  out  1  one-cycle strobe: `o_wb_rdt` holds a new instruction.
- `o_wb_rdt`  out  32  last fetched instruction; held until the next accepted ack.
- `o_misalign`  out  1  one-cycle pulse: a request arrived with `i_pc[1:0] != 0`.
- `o_bus_err`  out  1  one-cycle pulse: the watchdog expired.
- `o_busy`  out  1  high while in WAIT.

## Operation
- Two-state FSM.
- **IDLE**: `o_ibus_cyc` = 0, watchdog count = 0.
  - `i_fetch_req & i_flush`: request dropped; stay in IDLE; no pulse.
  - `i_fetch_req & !i_flush & i_pc[1:0] != 0`: `o_misalign` = 1 next cycle; stay in IDLE; no bus cycle.
  - `i_fetch_req & !i_flush & i_pc[1:0] == 0`: `o_ibus_adr` <= `i_pc`, `o_ibus_cyc` <= 1; go to WAIT.
- **WAIT**: `o_ibus_cyc` = 1; `o_ibus_adr` stable; `i_fetch_req` ignored. Priority, highest first:
  1. `i_flush`: `o_ibus_cyc` <= 0; go to IDLE; ack data in that cycle discarded; no `o_wb_en`.
  2. `i_ibus_ack`: `o_wb_rdt` <= `i_ibus_rdt`, `o_wb_en` <= 1, `o_ibus_cyc` <= 0; go to IDLE.
  3. `TIMEOUT != 0` and count == `TIMEOUT`-1: `o_bus_err` <= 1, `o_ibus_cyc` <= 0; go to IDLE; `o_wb_rdt` unchanged.
  4. Otherwise: count += 1.
- Ack wins over timeout when both occur in the same cycle.
- Watchdog counter width is clog2(TIMEOUT+1); it saturates and never wraps.
- `o_wb_en`, `o_misalign` and `o_bus_err` are single-cycle pulses and mutually exclusive.
- `i_ibus_ack` is ignored in IDLE: a stray ack has no effect.
- Reset in any state, mid-fetch included: immediately returns to IDLE and clears every output and the watchdog count. All outputs reset to 0, including `o_wb_rdt` and `o_ibus_adr`.

## Timing
- `i_fetch_req` sampled at edge 0 → `o_ibus_cyc`/`o_ibus_adr` valid from edge 0.
- Ack sampled at edge N → `o_wb_en` = 1 and `o_ibus_cyc` = 0 from edge N, for exactly one cycle.
- Minimum request-to-strobe latency: 2 cycles (ack in the first WAIT cycle).
- Back-to-back: a request in the cycle `o_wb_en` is high is accepted, since the FSM is already in IDLE. Sustained throughput is one instruction per 2 cycles with zero-wait-state memory.
- Flush sampled at edge N → `o_ibus_cyc` = 0 from edge N. The address is held until then.
- Misalign pulse: the cycle after the request.
- Timeout pulse: `TIMEOUT` cycles after entering WAIT.

## Structure
- Package `serv_ifetch_pkg` holds:
  - the state enum (IDLE, WAIT);
  - the alignment-check constant (2'b00);
  - a function returning the watchdog width for a given `TIMEOUT`.
- Sub-module `serv_ifetch_wdog`: clear/enable/expire counter parameterised by `TIMEOUT`. It ties `expire` to 0 when `TIMEOUT` = 0.
- The FSM, data capture and pulse registers stay in the top module.

## Test plan
- Request at `i_pc`=0x0000_0010, ack on the 3rd WAIT cycle with rdt=0x00A0_0093:
  - `o_ibus_adr`=0x10 throughout WAIT;
  - `o_wb_en` pulses once;
  - `o_wb_rdt`=0x00A0_0093 held;
  - `o_ibus_cyc` low the same cycle as the strobe.
- Request at `i_pc`=0x0000_0012:
  - `o_misalign` pulses one cycle;
  - `o_ibus_cyc` never rises;
  - `o_wb_rdt` unchanged.
- Flush and ack in the same WAIT cycle (rdt=0xDEAD_BEEF):
  - no `o_wb_en`;
  - `o_wb_rdt` keeps its previous value;
  - FSM in IDLE; next request accepted.
- `TIMEOUT`=4 with no ack:
  - `o_bus_err` pulses 4 cycles after WAIT is entered;
  - `o_ibus_cyc` drops;
  - an ack arriving on the expiry cycle instead gives `o_wb_en` and no error.
- Zero-wait ack with a new request in every `o_wb_en` cycle, PCs 0x0, 0x4, 0x8:
  - three strobes, 2 cycles apart;
  - addresses in order.
- `i_rst` asserted asynchronously mid-WAIT:
  - all outputs 0 immediately;
  - a stray ack after reset is ignored.
